// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with tear-free
// frame-boundary capture of a 16-bit hex value, per-digit decimal points and blanking.
module seven_seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic        pending,
  output logic [1:0]  digit_sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [15:0]   disp_value, pend_value;
  logic [3:0]    disp_dp, pend_dp;
  logic [3:0]    disp_blank, pend_blank;

  logic          tick;
  logic          wrap;
  logic          in_guard;
  logic [3:0]    cur_nibble;

  // Handshake: load is a fire-and-forget strobe with no ready; every cycle it is
  // high captures value/dp/blank into pending, and the last capture before a wrap wins.

  assign tick       = (cnt == CNT_MAX);
  assign wrap       = tick && (digit_sel == 2'd3);
  assign in_guard   = (cnt < GUARD_C);
  assign cur_nibble = disp_value[{digit_sel, 2'b00} +: 4];

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan sequencing and capture. On a load/wrap collision the display takes the
  // pre-edge pending contents while the new load refills pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_sel  <= 2'd0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pending    <= 1'b0;
    end else begin
      if (tick) begin
        cnt       <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (wrap && pending) begin
        disp_value <= pend_value;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Pin drivers are registered, so they lag cnt/digit_sel by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (in_guard) begin
        an <= 8'hFF;
      end else begin
        an <= ~(8'b0000_0001 << digit_sel);
      end
      if (in_guard || disp_blank[digit_sel]) begin
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end else begin
        seg  <= hex_decode(cur_nibble);
        dp_n <= ~disp_dp[digit_sel];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed self-checking bench for seven_seg_scan_driver at CLK_DIV=8, GUARD=2.
// Sample k is taken on the falling edge after the k-th rising edge since reset release.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        pending;
  logic [1:0]  digit_sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int n_checks;
  int n_fail;
  int k;

  logic [7:0] exp_q[$];

  seven_seg_scan_driver #(.CLK_DIV(8), .GUARD(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp         (dp),
    .blank      (blank),
    .load       (load),
    .pending    (pending),
    .digit_sel  (digit_sel),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    dp    = '0;
    blank = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v;
    dp    = d;
    blank = b;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1 || pending !== 1'b0 ||
        digit_sel !== 2'd0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: an=%h seg=%h dp_n=%b pending=%b sel=%0d fd=%b, need FF 7F 1 0 0 0",
               an, seg, dp_n, pending, digit_sel, frame_done);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      n_checks++;
      if (an !== 8'hFF) begin
        n_fail++;
        $display("FAIL reset_guard k=%0d: an=%h need FF", k, an);
      end
    end
    step();
    n_checks++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL reset_first_digit: an=%h seg=%h need FE 40", an, seg);
    end
    drive_load(16'h1234, 4'hF, 4'h0);
    n_checks++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pending_set: pending=%b need 1", pending);
    end
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1 || pending !== 1'b0 || digit_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async_midslot: an=%h seg=%h dp_n=%b pending=%b sel=%0d, need FF 7F 1 0 0",
               an, seg, dp_n, pending, digit_sel);
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] an_tab[4];
    logic [7:0] exp_an;
    an_tab[0] = 8'hFE;
    an_tab[1] = 8'hFD;
    an_tab[2] = 8'hFB;
    an_tab[3] = 8'hF7;
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 8; c++)
          exp_q.push_back((c < 2) ? 8'hFF : an_tab[d]);
    for (int i = 1; i <= 64; i++) begin
      step();
      exp_an = exp_q.pop_front();
      n_checks++;
      if (an !== exp_an) begin
        n_fail++;
        $display("FAIL scan_an k=%0d: an=%h need %h", k, an, exp_an);
      end
      n_checks++;
      if (seg !== ((exp_an == 8'hFF) ? 7'h7F : 7'h40)) begin
        n_fail++;
        $display("FAIL scan_seg k=%0d: seg=%h", k, seg);
      end
      n_checks++;
      if (digit_sel !== 2'((i / 8) % 4)) begin
        n_fail++;
        $display("FAIL scan_sel k=%0d: sel=%0d need %0d", k, digit_sel, (i / 8) % 4);
      end
      n_checks++;
      if (frame_done !== ((i % 32) == 0)) begin
        n_fail++;
        $display("FAIL scan_frame_done k=%0d: fd=%b need %b", k, frame_done, (i % 32) == 0);
      end
    end
  endtask

  task automatic test_decode();
    logic [6:0] exp_seg[4];
    logic       exp_dpn[4];
    exp_seg[0] = 7'h40; exp_seg[1] = 7'h0E; exp_seg[2] = 7'h12; exp_seg[3] = 7'h08;
    exp_dpn[0] = 1'b1;  exp_dpn[1] = 1'b1;  exp_dpn[2] = 1'b0;  exp_dpn[3] = 1'b1;
    do_reset();
    drive_load(16'hA5F0, 4'b0100, 4'b0000);
    n_checks++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_pending_rise: pending=%b need 1", pending);
    end
    step_to(31);
    n_checks++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_pending_hold: pending=%b need 1", pending);
    end
    step_to(32);
    n_checks++;
    if (pending !== 1'b0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_wrap: pending=%b fd=%b need 0 1", pending, frame_done);
    end
    step_to(33);
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL decode_guard: an=%h seg=%h need FF 7F", an, seg);
    end
    for (int d = 0; d < 4; d++) begin
      step_to(32 + 8 * d + 5);
      n_checks++;
      if (seg !== exp_seg[d] || dp_n !== exp_dpn[d]) begin
        n_fail++;
        $display("FAIL decode_digit%0d: seg=%h dp_n=%b need %h %b", d, seg, dp_n, exp_seg[d], exp_dpn[d]);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [6:0] exp_seg[4];
    exp_seg[0] = 7'h00; exp_seg[1] = 7'h78; exp_seg[2] = 7'h02; exp_seg[3] = 7'h12;
    do_reset();
    step_to(10);
    drive_load(16'h1234, 4'h0, 4'h0);
    step_to(19);
    drive_load(16'h5678, 4'h0, 4'h0);
    step_to(24);
    n_checks++;
    if (an !== 8'hFB || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL tear_cur_digit2: an=%h seg=%h need FB 40", an, seg);
    end
    step_to(30);
    n_checks++;
    if (an !== 8'hF7 || seg !== 7'h40) begin
      n_fail++;
      $display("FAIL tear_cur_digit3: an=%h seg=%h need F7 40", an, seg);
    end
    for (int d = 0; d < 4; d++) begin
      step_to(32 + 8 * d + 5);
      n_checks++;
      if (seg !== exp_seg[d]) begin
        n_fail++;
        $display("FAIL tear_next_digit%0d: seg=%h need %h", d, seg, exp_seg[d]);
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    step_to(5);
    drive_load(16'h1111, 4'h0, 4'h0);
    step_to(31);
    drive_load(16'h2222, 4'h0, 4'h0);
    n_checks++;
    if (pending !== 1'b1 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_wrap: pending=%b fd=%b need 1 1", pending, frame_done);
    end
    for (int d = 0; d < 4; d++) begin
      step_to(32 + 8 * d + 5);
      n_checks++;
      if (seg !== 7'h79) begin
        n_fail++;
        $display("FAIL collide_frame1_digit%0d: seg=%h need 79", d, seg);
      end
    end
    n_checks++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_pending_kept: pending=%b need 1", pending);
    end
    step_to(64);
    n_checks++;
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_pending_clear: pending=%b need 0", pending);
    end
    for (int d = 0; d < 4; d++) begin
      step_to(64 + 8 * d + 5);
      n_checks++;
      if (seg !== 7'h24) begin
        n_fail++;
        $display("FAIL collide_frame2_digit%0d: seg=%h need 24", d, seg);
      end
    end
  endtask

  task automatic test_blank();
    do_reset();
    drive_load(16'h8888, 4'b1000, 4'b1000);
    step_to(53);
    n_checks++;
    if (an !== 8'hFB || seg !== 7'h00 || dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_digit2_lit: an=%h seg=%h dp_n=%b need FB 00 1", an, seg, dp_n);
    end
    step_to(58);
    n_checks++;
    if (an !== 8'hFF) begin
      n_fail++;
      $display("FAIL blank_guard: an=%h need FF", an);
    end
    for (int i = 59; i <= 64; i++) begin
      step_to(i);
      n_checks++;
      if (an !== 8'hF7 || seg !== 7'h7F || dp_n !== 1'b1) begin
        n_fail++;
        $display("FAIL blank_digit3 k=%0d: an=%h seg=%h dp_n=%b need F7 7F 1", k, an, seg, dp_n);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp       = '0;
    blank    = '0;
    test_reset();
    test_scan_order();
    test_decode();
    test_tear_free();
    test_collision();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
